// File: rtl/a2d_rr_intf.sv
// a2d_rr_intf: round-robin reader for an ADC128S-style 8-channel 12-bit SPI ADC.
// It converts battery (ch0), current (ch1), brake (ch3) and torque (ch4) in turn.
// The latest result of each channel is held in its own register.
// It contains its own SPI master: SCLK = clk/SCLK_DIV, idles high, 16-bit frames.
//
// Optional feature macro: A2D_CNV_TIMER_EN
//   defined   : a conversion starts only when the free-running CNV_PERIOD timer wraps
//   undefined : conversions run back to back (fast simulation build)
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   batt/curr/      latest 12-bit results of channels 0/1/3/4
//   brake/torque
//   SS_n, SCLK,     SPI master outputs (slave select, clock, data out)
//   MOSI
//   MISO            SPI data in from the ADC
module a2d_rr_intf #(
`ifdef A2D_CNV_TIMER_EN
    parameter int unsigned CNV_PERIOD = 16384,
`endif
    parameter int unsigned SCLK_DIV   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int unsigned DIV_W  = $clog2(SCLK_DIV);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned DAT_W  = 12;

    // Divider load makes the first SCLK fall land 8 clks after wrt.
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 8);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);

    typedef enum logic [1:0] {SPI_IDLE, SPI_FRONT, SPI_XFER, SPI_BACK} spi_state_t;
    typedef enum logic [1:0] {IDLE, CMD, WAIT, READ} state_t;

    // ------------------------------------------------------------------
    // SPI master
    // ------------------------------------------------------------------
    spi_state_t         spi_state;
    spi_state_t         spi_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [WORD_W-1:0]  shft_reg;
    logic               miso_smpl;
    logic               done;

    logic               wrt;
    logic [WORD_W-1:0]  cmd;

    logic               div_ld;
    logic               div_run;
    logic               div_half_ld;
    logic               do_shift;
    logic               do_smpl;
    logic               set_done;

    // SPI state register
    always_ff @(posedge clk) begin
        if (!rst_n) spi_state <= SPI_IDLE;
        else        spi_state <= spi_nxt;
    end

    // SPI next state and datapath controls
    always_comb begin
        spi_nxt     = spi_state;
        div_ld      = 1'b0;
        div_run     = 1'b0;
        div_half_ld = 1'b0;
        do_shift    = 1'b0;
        do_smpl     = 1'b0;
        set_done    = 1'b0;
        case (spi_state)
            SPI_IDLE: begin
                if (wrt) begin
                    div_ld  = 1'b1;
                    spi_nxt = SPI_FRONT;
                end
            end
            // Run up to the first SCLK fall, which only presents the MSB.
            SPI_FRONT: begin
                div_run = 1'b1;
                if (div_cnt == DIV_LAST) spi_nxt = SPI_XFER;
            end
            SPI_XFER: begin
                if (div_cnt == DIV_HALF) do_smpl = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    do_shift = 1'b1;
                    // Last shift: park the divider with SCLK high for the back porch.
                    if (bit_cnt == 4'hF) begin
                        div_half_ld = 1'b1;
                        spi_nxt     = SPI_BACK;
                    end else begin
                        div_run = 1'b1;
                    end
                end else begin
                    div_run = 1'b1;
                end
            end
            SPI_BACK: begin
                if (div_cnt == DIV_LAST) begin
                    set_done = 1'b1;
                    spi_nxt  = SPI_IDLE;
                end else begin
                    div_run = 1'b1;
                end
            end
            default: spi_nxt = SPI_IDLE;
        endcase
    end

    // SPI datapath: divider, bit counter, shift register, slave select
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= DIV_LAST;
            bit_cnt   <= '0;
            shft_reg  <= '0;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= set_done;
            if (div_ld)           div_cnt <= DIV_LOAD;
            else if (div_half_ld) div_cnt <= DIV_HALF;
            else if (div_run)     div_cnt <= div_cnt + DIV_W'(1);

            if (div_ld)        bit_cnt <= '0;
            else if (do_shift) bit_cnt <= bit_cnt + 4'd1;

            if (do_smpl) miso_smpl <= MISO;

            if (div_ld)        shft_reg <= cmd;
            else if (do_shift) shft_reg <= {shft_reg[WORD_W-2:0], miso_smpl};

            if (div_ld)        SS_n <= 1'b0;
            else if (set_done) SS_n <= 1'b1;
        end
    end

    assign SCLK = div_cnt[DIV_W-1];
    assign MOSI = shft_reg[WORD_W-1];

    // ------------------------------------------------------------------
    // Conversion pacing
    // ------------------------------------------------------------------
    logic cnv_start;

`ifdef A2D_CNV_TIMER_EN
    localparam int unsigned TMR_W = $clog2(CNV_PERIOD);
    logic [TMR_W-1:0] timer;

    // Free-running; wraps dropped while busy because only IDLE looks at it.
    always_ff @(posedge clk) begin
        if (!rst_n) timer <= '0;
        else        timer <= timer + TMR_W'(1);
    end

    assign cnv_start = (timer == TMR_W'(CNV_PERIOD - 1));
`else
    assign cnv_start = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Round-robin sequencer
    // ------------------------------------------------------------------
    state_t      state;
    state_t      nxt;
    logic [1:0]  rr_idx;
    logic [2:0]  chnl;
    logic        res_ld;

    // rr_idx to physical ADC channel
    always_comb begin
        chnl = 3'd0;
        case (rr_idx)
            2'd0:    chnl = 3'd0;
            2'd1:    chnl = 3'd1;
            2'd2:    chnl = 3'd3;
            default: chnl = 3'd4;
        endcase
    end

    assign cmd = {2'b00, chnl, 11'h000};

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Two frames per conversion: the ADC answers the previous frame's channel.
    always_comb begin
        nxt    = state;
        wrt    = 1'b0;
        res_ld = 1'b0;
        case (state)
            IDLE: begin
                if (cnv_start) begin
                    wrt = 1'b1;
                    nxt = CMD;
                end
            end
            CMD: begin
                if (done) nxt = WAIT;
            end
            WAIT: begin
                wrt = 1'b1;
                nxt = READ;
            end
            READ: begin
                if (done) begin
                    res_ld = 1'b1;
                    nxt    = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Result registers and channel index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_idx <= '0;
            batt   <= '0;
            curr   <= '0;
            brake  <= '0;
            torque <= '0;
        end else if (res_ld) begin
            rr_idx <= rr_idx + 2'd1;
            case (rr_idx)
                2'd0:    batt   <= shft_reg[DAT_W-1:0];
                2'd1:    curr   <= shft_reg[DAT_W-1:0];
                2'd2:    brake  <= shft_reg[DAT_W-1:0];
                default: torque <= shft_reg[DAT_W-1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_rr_intf.sv
// tb_a2d_rr_intf: bench for a2d_rr_intf (default build, back-to-back conversions).
// It contains an ADC128S-style slave model that answers each frame with the
// channel addressed by the previous frame. Expected command words and results
// are queued when a round is started, and they are compared when the DUT
// produces them.
module tb_a2d_rr_intf;

    localparam int unsigned DRAIN_LIMIT = 15000;

    typedef struct packed {
        logic [1:0]  idx;
        logic [11:0] val;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] batt, curr, brake, torque;
    logic        SS_n, SCLK, MOSI;
    logic        MISO;

    int          checks   = 0;
    int          failures = 0;
    int          idle_bad = 0;

    logic [11:0] adc_val [8];
    logic [11:0] exp_out [4];
    logic [15:0] exp_cmd [$];
    res_t        exp_res [$];

    logic [15:0] cmd_tab [4] = '{16'h0000, 16'h0800, 16'h1800, 16'h2000};
    int          chmap   [4] = '{0, 1, 3, 4};

    a2d_rr_intf dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .batt   (batt),
        .curr   (curr),
        .brake  (brake),
        .torque (torque),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One full round: each command twice, one result per channel.
    task automatic push_round();
        res_t r;
        for (int i = 0; i < 4; i++) begin
            exp_cmd.push_back(cmd_tab[i]);
            exp_cmd.push_back(cmd_tab[i]);
            r.idx = 2'(i);
            r.val = adc_val[chmap[i]];
            exp_res.push_back(r);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_res.size() != 0) && n < DRAIN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 16'(exp_cmd.size() + exp_res.size()), 16'd0);
    endtask

    // ADC slave model plus frame/result monitor
    logic        ss_q = 1'b1;
    logic        sclk_q = 1'b1;
    logic [15:0] tx_word = '0;
    logic [15:0] rx = '0;
    logic [2:0]  prev_chnl = '0;
    int          rises = 0;
    int          falls = 0;
    int          txn_cnt = 0;
    logic        res_pend = 1'b0;

    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            txn_cnt  = 0;
            res_pend = 1'b0;
            rises    = 0;
            falls    = 0;
            MISO     = 1'b0;
        end else begin
            if (res_pend) begin
                res_pend = 1'b0;
                if (exp_res.size() != 0) begin
                    r = exp_res.pop_front();
                    exp_out[r.idx] = r.val;
                    chk("batt",   16'(batt),   16'(exp_out[0]));
                    chk("curr",   16'(curr),   16'(exp_out[1]));
                    chk("brake",  16'(brake),  16'(exp_out[2]));
                    chk("torque", 16'(torque), 16'(exp_out[3]));
                end
            end
            if (ss_q && !SS_n) begin
                tx_word = {4'h0, adc_val[prev_chnl]};
                MISO    = tx_word[15];
                rises   = 0;
                falls   = 0;
                rx      = '0;
            end
            if (!SS_n) begin
                if (sclk_q && !SCLK) begin
                    if (falls > 0 && falls < 16) MISO = tx_word[15-falls];
                    falls++;
                end
                if (!sclk_q && SCLK) begin
                    rx = {rx[14:0], MOSI};
                    rises++;
                end
            end else if (!SCLK || !sclk_q) begin
                idle_bad++;
            end
            if (!ss_q && SS_n) begin
                prev_chnl = rx[13:11];
                if (exp_cmd.size() != 0) begin
                    chk("cmd_word", rx, exp_cmd.pop_front());
                    chk("sclk_rises", 16'(rises), 16'd16);
                end
                if (txn_cnt % 2 == 1) res_pend = 1'b1;
                txn_cnt++;
            end
        end
        ss_q   = SS_n;
        sclk_q = SCLK;
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'hFFF;
        for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;

        // Reset held
        repeat (5) @(negedge clk);
        chk("rst_batt",   16'(batt),   16'h0);
        chk("rst_curr",   16'(curr),   16'h0);
        chk("rst_brake",  16'(brake),  16'h0);
        chk("rst_torque", 16'(torque), 16'h0);
        chk("rst_ss_n",   16'(SS_n),   16'h1);
        chk("rst_sclk",   16'(SCLK),   16'h1);
        chk("rst_mosi",   16'(MOSI),   16'h0);

        // All channels full scale
        rst_n = 1'b1;
        push_round();
        drain();

        // Reset in the middle of a frame with a new model value
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h001;
        repeat (300) @(negedge clk);
        chk("mid_ss_low", 16'(SS_n), 16'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ss_n",   16'(SS_n),   16'h1);
        chk("abort_sclk",   16'(SCLK),   16'h1);
        chk("abort_batt",   16'(batt),   16'h0);
        chk("abort_curr",   16'(curr),   16'h0);
        chk("abort_brake",  16'(brake),  16'h0);
        chk("abort_torque", 16'(torque), 16'h0);
        for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;
        exp_cmd.delete();
        exp_res.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_round();
        drain();

        // Distinct per-channel values
        adc_val[0] = 12'h123;
        adc_val[1] = 12'h456;
        adc_val[3] = 12'h789;
        adc_val[4] = 12'hABC;
        push_round();
        drain();

        chk("sclk_idle_edges", 16'(idle_bad), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
